dds_sine_gen: RTL and testbench

- Direct digital synthesizer: PHASE_WIDTH-bit phase accumulator driving a full-wave sine lookup table.
- Produces an unsigned, offset-binary sine sample every clock.
- Used as a stimulus and tone source ahead of filter blocks, e.g. two instances summed to form a multi-tone test signal.

---
 rtl/dds_sine_gen.sv | 121 ++++++++++++
 tb/tb_dds_sine_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dds_sine_gen.sv
`default_nettype none
// ============================================================================
// Module   : dds_sine_gen
// Purpose  : Phase-accumulator DDS with full-wave sine table, offset-binary out.
//            Optional cosine port enabled by defining DDS_COS_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sine_gen #(
  parameter int PHASE_WIDTH    = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [PHASE_WIDTH-1:0] phase_inc_i,
`ifdef DDS_COS_OUT_EN
  output logic [DATA_WIDTH-1:0]  cos_o,
`endif
  output logic [DATA_WIDTH-1:0]  sin_o
);

  localparam int unsigned c_depth = 1 << LUT_ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] c_mid = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // pi scaled by 2^62, all arithmetic below is Q62 fixed point
  localparam logic [127:0] c_pi_q62 = 128'h0000_0000_0000_0000_C90F_DAA2_2168_C234;

  function automatic logic [DATA_WIDTH-1:0] sine_entry(input int unsigned idx);
    int unsigned  quarter;
    int unsigned  quad;
    int unsigned  rem;
    int unsigned  k;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] mag;
    logic [127:0] mid;
    quarter = c_depth / 4;
    quad    = idx / quarter;
    rem     = idx % quarter;
    k       = (quad == 1 || quad == 3) ? (quarter - rem) : rem;
    // Reduce to the first quadrant so the Taylor series stays short and positive
    x    = (c_pi_q62 * 128'(2 * k)) / 128'(c_depth);
    x2   = (x * x) >> 62;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x2) >> 62;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    // Rounding the magnitude then applying sign gives half-away-from-zero
    mag = ((128'(c_mid) - 128'd1) * sum + (128'd1 << 61)) >> 62;
    mid = 128'(c_mid);
    return (quad >= 2) ? DATA_WIDTH'(mid - mag) : DATA_WIDTH'(mid + mag);
  endfunction

  logic [DATA_WIDTH-1:0] w_rom [c_depth];

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] c_val = sine_entry(gi);
    assign w_rom[gi] = c_val;
  end

  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
  logic [DATA_WIDTH-1:0]     rom_q, rom_d;
  logic [DATA_WIDTH-1:0]     sin_q, sin_d;
  logic [LUT_ADDR_WIDTH-1:0] w_addr;

  assign w_addr = phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];

  always_comb begin
    phase_d = en_i ? (phase_q + phase_inc_i) : phase_q;
    rom_d   = w_rom[w_addr];
    sin_d   = rom_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      rom_q   <= c_mid;
      sin_q   <= c_mid;
    end else begin
      phase_q <= phase_d;
      rom_q   <= rom_d;
      sin_q   <= sin_d;
    end
  end

  assign sin_o = sin_q;

`ifdef DDS_COS_OUT_EN
  logic [LUT_ADDR_WIDTH-1:0] w_cos_addr;
  logic [DATA_WIDTH-1:0]     rom_cos_q, rom_cos_d;
  logic [DATA_WIDTH-1:0]     cos_q, cos_d;

  // Quarter-table offset wraps naturally in the address width
  assign w_cos_addr = w_addr + LUT_ADDR_WIDTH'(c_depth / 4);

  always_comb begin
    rom_cos_d = w_rom[w_cos_addr];
    cos_d     = rom_cos_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_cos_q <= c_mid;
      cos_q     <= c_mid;
    end else begin
      rom_cos_q <= rom_cos_d;
      cos_q     <= cos_d;
    end
  end

  assign cos_o = cos_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dds_sine_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sine_gen
// Purpose  : Directed self-checking bench for dds_sine_gen (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sine_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] phase_inc_i;
  logic [15:0] sin_o;
`ifdef DDS_COS_OUT_EN
  logic [15:0] cos_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dds_sine_gen #(
    .PHASE_WIDTH   (16),
    .DATA_WIDTH    (16),
    .LUT_ADDR_WIDTH(10)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .phase_inc_i(phase_inc_i),
`ifdef DDS_COS_OUT_EN
    .cos_o      (cos_o),
`endif
    .sin_o      (sin_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [15:0] quarter_sin [4];
  logic [15:0] quarter_cos [4];

  initial begin
    quarter_sin[0] = 16'd65535; quarter_sin[1] = 16'd32768;
    quarter_sin[2] = 16'd1;     quarter_sin[3] = 16'd32768;
    quarter_cos[0] = 16'd32768; quarter_cos[1] = 16'd1;
    quarter_cos[2] = 16'd32768; quarter_cos[3] = 16'd65535;

    // Reset held with enable and a nonzero step
    rst_i = 1'b1; en_i = 1'b1; phase_inc_i = 16'd2000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_sin", 32'(sin_o), 32'd32768);
      check("reset_phase", 32'(dut.phase_q), 32'd0);
    end
    rst_i = 1'b0;

    // First enabled edges: midscale until phase 2000 (addr 31) reaches the output
    tick();
    check("start1_sin", 32'(sin_o), 32'd32768);
    check("start1_phase", 32'(dut.phase_q), 32'd2000);
    tick();
    check("start2_sin", 32'(sin_o), 32'd32768);
    tick();
    check("start3_sin_rom31", 32'(sin_o), 32'd38963);
    check("start3_phase", 32'(dut.phase_q), 32'd6000);

    // Accumulator wraps at step 33: 66000 mod 65536 = 464, addr 7
    for (int i = 4; i <= 33; i++) tick();
    check("wrap_phase", 32'(dut.phase_q), 32'd464);
    tick();
    tick();
    check("wrap_sin_rom7", 32'(sin_o), 32'd34175);

    // Mid-run reset pulse then zero increment
    rst_i = 1'b1;
    tick();
    check("midrst_sin", 32'(sin_o), 32'd32768);
    check("midrst_phase", 32'(dut.phase_q), 32'd0);
    rst_i = 1'b0; phase_inc_i = 16'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("zero_inc_sin", 32'(sin_o), 32'd32768);
    end
    check("zero_inc_phase", 32'(dut.phase_q), 32'd0);

    // Quarter-turn increment from phase 0
    phase_inc_i = 16'd16384;
    tick();
    check("qt1_phase", 32'(dut.phase_q), 32'd16384);
    tick();
    check("qt2_sin", 32'(sin_o), 32'd32768);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("qt_sin", 32'(sin_o), 32'(quarter_sin[i % 4]));
`ifdef DDS_COS_OUT_EN
      check("qt_cos", 32'(cos_o), 32'(quarter_cos[i % 4]));
`endif
    end

    // Enable gating: reach phase 2000 with step 200, then freeze
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; phase_inc_i = 16'd200;
    for (int i = 0; i < 10; i++) tick();
    check("gate_run_phase", 32'(dut.phase_q), 32'd2000);
    en_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("gate_hold_phase", 32'(dut.phase_q), 32'd2000);
      if (i >= 2) check("gate_hold_sin", 32'(sin_o), 32'd38963);
    end
    en_i = 1'b1;
    tick();
    check("gate_resume_phase", 32'(dut.phase_q), 32'd2200);
    en_i = 1'b0;
    tick();
    tick();
    check("gate_resume_sin_rom34", 32'(sin_o), 32'd39554);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
